// File: rtl/mpc_mvmult_row_mac_if.sv
// Bus bundle for the MPC matrix-vector row engine.
// Carries the start/busy/done/result handshake toward the controller and
// the two 1R memory ports (coefficient ROM and state/decision vector).
//   slave  : the row engine (accepts start, drives memory addresses/enables)
//   master : controller + memories (drives start and the read data)
`timescale 1ns/1ps
interface mpc_mvmult_row_mac_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] y;
    logic                  sat;
    logic [ADDR_WIDTH-1:0] coef_address0;
    logic                  coef_ce0;
    logic [DATA_WIDTH-1:0] coef_q0;
    logic [ADDR_WIDTH-1:0] x_address0;
    logic                  x_ce0;
    logic [DATA_WIDTH-1:0] x_q0;

    modport slave (
        input  start,
        output busy, done, y, sat,
        output coef_address0, coef_ce0,
        input  coef_q0,
        output x_address0, x_ce0,
        input  x_q0
    );

    modport master (
        output start,
        input  busy, done, y, sat,
        input  coef_address0, coef_ce0,
        output coef_q0,
        input  x_address0, x_ce0,
        output x_q0
    );
endinterface

// File: rtl/mpc_mvmult_row_mac.sv
// Row engine for the dense-constraint matrix-vector product of the MPC
// controller. On start it streams one coefficient row and the matching
// vector entries out of two 1-cycle-latency memories, forms the Q-format
// dot product in a wide accumulator and returns one rounded, saturated
// DATA_WIDTH-bit result with a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : start/busy/done/y/sat handshake plus coef_* and x_* memory ports
`timescale 1ns/1ps
module mpc_mvmult_row_mac #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned ROW_LEN    = 8,
    parameter int unsigned ACC_WIDTH  = 36
) (
    input logic                  clk,
    input logic                  reset,
    mpc_mvmult_row_mac_if.slave  bus
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_LEN - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic                          ce_q, ce_d;
    logic                          drain_q, drain_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [DATA_WIDTH-1:0]         y_q, y_d;
    logic                          sat_q, sat_d;
    logic                          rd_vld_q, rd_vld_d;
    logic                          prod_vld_q, prod_vld_d;
    logic signed [PROD_WIDTH-1:0]  prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;

    logic signed [DATA_WIDTH-1:0]  coef_s, x_s;
    logic signed [ACC_WIDTH-1:0]   acc_rnd, r_full;

    always_comb begin
        coef_s  = bus.coef_q0;
        x_s     = bus.x_q0;
        acc_rnd = acc_q + RND_HALF;
        r_full  = acc_rnd >>> FRAC_BITS;

        state_d    = state_q;
        addr_d     = addr_q;
        ce_d       = 1'b0;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        y_d        = y_q;
        sat_d      = sat_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        // Valid flags trail the read enable: data arrives one cycle after
        // ce, the product one cycle after that.
        rd_vld_d   = ce_q;
        prod_vld_d = rd_vld_q;

        if (rd_vld_q) begin
            prod_d = coef_s * x_s;
        end
        if (prod_vld_q) begin
            acc_d = acc_q + ACC_WIDTH'(prod_q);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    addr_d  = '0;
                    ce_d    = 1'b1;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                end
            end
            S_ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    ce_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                // Two cycles: last data -> product -> accumulator.
                if (drain_q) begin
                    state_d = S_OUT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (r_full > Y_MAX) begin
                    y_d   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                    sat_d = 1'b1;
                end else if (r_full < Y_MIN) begin
                    y_d   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                    sat_d = 1'b1;
                end else begin
                    y_d   = r_full[DATA_WIDTH-1:0];
                    sat_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            ce_q       <= 1'b0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= '0;
            sat_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ce_q       <= ce_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
            sat_q      <= sat_d;
            rd_vld_q   <= rd_vld_d;
            prod_vld_q <= prod_vld_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.y             = y_q;
    assign bus.sat           = sat_q;
    assign bus.coef_address0 = addr_q;
    assign bus.coef_ce0      = ce_q;
    assign bus.x_address0    = addr_q;
    assign bus.x_ce0         = ce_q;

endmodule
